mac_seq: RTL

MAC_SEQ -- requirements
Module: mac_seq

---
 rtl/mac_seq_pkg.sv | 29 ++
 rtl/mac_seq_lat_pipe.sv | 54 +++++
 rtl/mac_seq.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mac_seq_pkg.sv
// Shared types and widths for the spiking MAC sequencer.
// Holds the FSM encoding and the saturating potential accumulate.
package mac_seq_pkg;

    localparam int V_W   = 24;
    localparam int SUM_W = 21;
    localparam int PIX_W = 25;
    localparam int T_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_PIX = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_FIN      = 3'd4
    } state_e;

    // Clamp at all-ones instead of wrapping when the membrane potential overflows.
    function automatic logic [V_W-1:0] sat_add(input logic [V_W-1:0] a, input logic [SUM_W-1:0] b);
        logic [V_W:0] s;
        s = {1'b0, a} + {{(V_W + 1 - SUM_W){1'b0}}, b};
        if (s[V_W]) begin
            return {V_W{1'b1}};
        end else begin
            return s[V_W-1:0];
        end
    endfunction

endpackage

// File: rtl/mac_seq_lat_pipe.sv
// Valid/neuron-index delay line matching the external MAC latency.
// The last stage is the capture tap; pend flags work still in flight behind it.
module mac_lat_pipe #(
    parameter int DEPTH = 2,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             tap_valid,
    output logic [IDX_W-1:0] tap_idx,
    output logic             pend
);

    logic [DEPTH-1:0] vld_r;
    logic [IDX_W-1:0] idx_r [DEPTH];

    // First stage samples the issue slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r[0] <= 1'b0;
            idx_r[0] <= '0;
        end else begin
            vld_r[0] <= in_valid;
            idx_r[0] <= in_idx;
        end
    end

    for (genvar g = 1; g < DEPTH; g++) begin : g_stage
        // Later stages shift the slot towards the tap.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_r[g] <= 1'b0;
                idx_r[g] <= '0;
            end else begin
                vld_r[g] <= vld_r[g-1];
                idx_r[g] <= idx_r[g-1];
            end
        end
    end

    // Anything ahead of the tap means the pipeline is not empty after this edge.
    always_comb begin
        pend = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pend = pend | vld_r[i];
        end
    end

    assign tap_valid = vld_r[DEPTH-1];
    assign tap_idx   = idx_r[DEPTH-1];

endmodule

// File: rtl/mac_seq.sv
// Timestep scheduler feeding an external MAC: issues one neuron per cycle,
// integrates returned sums into saturating potentials and emits spike events.
module mac_seq
    import mac_seq_pkg::*;
#(
    parameter int NUM_NEU = 8,
    parameter int TSTEPS  = 16,
    parameter int MAC_LAT = 2,
    localparam int IDX_W  = $clog2(NUM_NEU)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [V_W-1:0]   thresh,
    output logic             busy,
    output logic             done,
    input  logic             pix_valid,
    input  logic [PIX_W-1:0] pix_data,
    output logic             pix_ready,
    output logic [PIX_W-1:0] mac_pixels,
    output logic [IDX_W-1:0] w_addr,
    input  logic [SUM_W-1:0] mac_sum_i,
    output logic             spike_valid,
    output logic [IDX_W-1:0] spike_neu,
    output logic [T_W-1:0]   spike_t
);

    localparam logic [IDX_W-1:0] LAST_NEU = IDX_W'(NUM_NEU - 1);
    localparam logic [T_W-1:0]   LAST_T   = T_W'(TSTEPS - 1);

    state_e           state_r;
    logic [V_W-1:0]   thresh_r;
    logic [T_W-1:0]   t_r;
    logic [V_W-1:0]   pot_r [NUM_NEU];

    logic             iss_valid_s;
    logic             tap_valid_s;
    logic [IDX_W-1:0] tap_idx_s;
    logic             pend_s;
    logic [V_W-1:0]   cap_sum_s;
    logic             cap_fire_s;

    mac_lat_pipe #(
        .DEPTH (MAC_LAT),
        .IDX_W (IDX_W)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iss_valid_s),
        .in_idx    (w_addr),
        .tap_valid (tap_valid_s),
        .tap_idx   (tap_idx_s),
        .pend      (pend_s)
    );

    // Issue qualifier and integrate-and-fire decision for the tapped neuron.
    always_comb begin
        iss_valid_s = (state_r == ST_ISSUE);
        cap_sum_s   = sat_add(pot_r[tap_idx_s], mac_sum_i);
        cap_fire_s  = (cap_sum_s >= thresh_r);
    end

    // Run-control FSM, potential update and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            thresh_r    <= '0;
            t_r         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pix_ready   <= 1'b0;
            mac_pixels  <= '0;
            w_addr      <= '0;
            spike_valid <= 1'b0;
            spike_neu   <= '0;
            spike_t     <= '0;
            for (int i = 0; i < NUM_NEU; i++) begin
                pot_r[i] <= '0;
            end
        end else begin
            done        <= 1'b0;
            spike_valid <= 1'b0;
            if (tap_valid_s) begin
                spike_valid <= cap_fire_s;
                if (cap_fire_s) begin
                    spike_neu        <= tap_idx_s;
                    spike_t          <= t_r;
                    pot_r[tap_idx_s] <= '0;
                end else begin
                    pot_r[tap_idx_s] <= cap_sum_s;
                end
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_NEU; i++) begin
                            pot_r[i] <= '0;
                        end
                        thresh_r  <= thresh;
                        t_r       <= '0;
                        busy      <= 1'b1;
                        pix_ready <= 1'b1;
                        state_r   <= ST_WAIT_PIX;
                    end
                end
                ST_WAIT_PIX: begin
                    if (pix_valid) begin
                        mac_pixels <= pix_data;
                        w_addr     <= '0;
                        pix_ready  <= 1'b0;
                        state_r    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_addr == LAST_NEU) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        w_addr <= w_addr + IDX_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // The tapped slot is captured on this same edge, so only earlier stages matter.
                    if (!pend_s) begin
                        if (t_r == LAST_T) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_r <= ST_FIN;
                        end else begin
                            t_r       <= t_r + T_W'(1);
                            pix_ready <= 1'b1;
                            state_r   <= ST_WAIT_PIX;
                        end
                    end
                end
                ST_FIN: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    pix_ready <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
